mem_io_bridge: RTL and testbench
================================

Name: mem_io_bridge

Overview:
- Memory-side stage directly downstream of the CPU core.
- Consumes the core's mem_cmd/mem_addr/write_data and returns read_data.
- Decodes the 9-bit address space into an external 256x16 RAM, an LED output register, synchronised slide switches, and a prescaled 16-bit timer with compare flag and interrupt.
- Holds all peripheral state. The CPU needs no knowledge of devices beyond their addresses.

Parameters:
PRESCALE, 50, clock cycles per timer tick (minimum 1; 1 means a tick every enabled cycle)
RAM_DEPTH_LOG2, 8, RAM address width; RAM occupies mem_addr 0x000-0x0FF

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous active-high reset
mem_cmd  input  2  00 none, 01 read, 10 write, 11 reserved (treated as none, flags bus_err)
mem_addr  input  9  word address from core
write_data  input  16  store data from core
read_data  output  16  load data to core, combinational
ram_write  output  1  RAM write enable
ram_addr  output  8  mem_addr[7:0]
ram_din  output  16  write_data passthrough
ram_dout  input  16  RAM read data
SW  input  8  asynchronous slide switches
LEDR  output  8  LED register
timer_irq  output  1  timer interrupt request
bus_err  output  1  sticky access error

Behaviour:
- Address map, decided:
  - 0x000-0x0FF RAM
  - 0x100 LED (W)
  - 0x140 SW (R)
  - 0x180 TCOUNT (R)
  - 0x181 TCTRL (R/W)
  - 0x182 TCMP (R/W)
  - 0x183 TSTAT (R, clear-on-read)
  - All other addresses unmapped.
- Reset values (async): LEDR=0, TCOUNT=0, prescaler=0, TCTRL=0, TCMP=16'hFFFF, TSTAT=0, switch sync flops=0, bus_err=0, timer_irq=0.
- ram_write = (mem_cmd==10) and mem_addr[8]==0. Combinational, no added latency.
- read_data is combinational from current mem_cmd/mem_addr; it is 16'h0000 unless mem_cmd==01.
  - RAM range: ram_dout.
  - SW: {8'h00, sw_sync}.
  - TCOUNT: count.
  - TCTRL: {13'b0, irq_en, 1'b0, en}.
  - TCMP: compare.
  - TSTAT: {15'b0, match}.
  - Unmapped: 16'h0000.
- Writes take effect at the clock edge with mem_cmd==10:
  - LED <= write_data[7:0].
  - TCTRL: en<=bit0, irq_en<=bit2. Bit1 is a strobe that clears count and prescaler to 0 that edge; it is never stored.
  - TCMP <= write_data.
  - Writes to SW, TCOUNT and TSTAT are ignored and set bus_err.
- SW passes through a 2-flop synchroniser. A change on SW is visible at 0x140 after exactly 2 rising edges.
- Timer, when en=1:
  - The prescaler counts 0..PRESCALE-1.
  - A tick occurs in the cycle the prescaler equals PRESCALE-1; the prescaler then wraps to 0 and count increments.
  - count wraps FFFF->0000.
  - When en=0, the prescaler and count hold.
- match:
  - Sets on the edge where a tick makes the next count equal to TCMP.
  - Clears on the edge ending a read of 0x183.
  - If set and clear occur on the same edge, set wins.
- Clear strobe in the same cycle as a tick: clear wins, count=0, no match set. A TCMP write in the same cycle as a tick compares against the old TCMP.
- timer_irq = match & irq_en, registered-state driven, with no combinational path from the bus.
- bus_err is sticky until reset. It sets on:
  - mem_cmd==11,
  - any access to an unmapped address,
  - a write to a read-only register.
- RAM accesses never set bus_err.
- Reset asserted mid-operation clears all state immediately. ram_write is 0 while reset is high.

Test Plan:
- Reset with mem_cmd=10, addr=0x100, data=0x00AB held -> LEDR=0 and ram_write=0 while reset high; after release, next edge gives LEDR=0xAB.
- Write 0x1234 to 0x005 then read 0x005 (RAM model) -> ram_write=1 for one cycle with ram_addr=0x05; read_data=0x1234 during the read; bus_err=0.
- SW changes 0x00->0x5A -> read of 0x140 returns 0x0000 for two edges, then 0x005A.
- PRESCALE=4; write TCMP=3, TCTRL=0x5 -> count reaches 3 after 12 cycles; match=1, timer_irq=1; read 0x183 returns 0x0001, then 0x0000 on the next read.
- Clear strobe (TCTRL=0x3) on a tick cycle with count=2 -> count=0, match stays 0; count=0xFFFF plus a tick wraps to 0x0000.
- Read 0x1FF, write 0x180, mem_cmd=11 (each after reset) -> each sets bus_err=1, and it stays 1; read 0x1FF returns 0x0000.

Source files
------------

// File: rtl/mem_io_bridge.sv
// Memory-side bridge behind the CPU core: decodes a 9-bit word address space
// into external RAM, an LED register, synchronised switches and a prescaled timer.
module mem_io_bridge #(
  parameter int unsigned PRESCALE       = 50,
  parameter int unsigned RAM_DEPTH_LOG2 = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [1:0]                mem_cmd,
  input  logic [8:0]                mem_addr,
  input  logic [15:0]               write_data,
  output logic [15:0]               read_data,
  output logic                      ram_write,
  output logic [RAM_DEPTH_LOG2-1:0] ram_addr,
  output logic [15:0]               ram_din,
  input  logic [15:0]               ram_dout,
  input  logic [7:0]                SW,
  output logic [7:0]                LEDR,
  output logic                      timer_irq,
  output logic                      bus_err
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

  localparam logic [8:0] ADDR_LED    = 9'h100;
  localparam logic [8:0] ADDR_SW     = 9'h140;
  localparam logic [8:0] ADDR_TCOUNT = 9'h180;
  localparam logic [8:0] ADDR_TCTRL  = 9'h181;
  localparam logic [8:0] ADDR_TCMP   = 9'h182;
  localparam logic [8:0] ADDR_TSTAT  = 9'h183;

  logic          is_read, is_write;
  logic          sel_ram, sel_led, sel_sw, sel_tcount, sel_tctrl, sel_tcmp, sel_tstat;
  logic          mapped, read_only, err_c;
  logic          tick, clr_strobe, match_set, match_clr;
  logic [15:0]   count_inc;

  logic [7:0]    sw_meta, sw_sync;
  logic [PW-1:0] prescaler;
  logic [15:0]   count, compare;
  logic          en, irq_en, match;

  // Address decode and error detection for the current bus command
  always_comb begin
    is_read    = (mem_cmd == 2'b01);
    is_write   = (mem_cmd == 2'b10);
    sel_ram    = ~mem_addr[8];
    sel_led    = (mem_addr == ADDR_LED);
    sel_sw     = (mem_addr == ADDR_SW);
    sel_tcount = (mem_addr == ADDR_TCOUNT);
    sel_tctrl  = (mem_addr == ADDR_TCTRL);
    sel_tcmp   = (mem_addr == ADDR_TCMP);
    sel_tstat  = (mem_addr == ADDR_TSTAT);
    mapped     = sel_ram | sel_led | sel_sw | sel_tcount | sel_tctrl | sel_tcmp | sel_tstat;
    read_only  = sel_sw | sel_tcount | sel_tstat;
    err_c      = (mem_cmd == 2'b11) | ((is_read | is_write) & ~mapped) | (is_write & read_only);
  end

  assign ram_write = is_write & sel_ram & ~reset;
  assign ram_addr  = mem_addr[RAM_DEPTH_LOG2-1:0];
  assign ram_din   = write_data;
  assign timer_irq = match & irq_en;

  // Combinational load path; LED is write-only and reads back as zero
  always_comb begin
    read_data = 16'h0000;
    if (is_read) begin
      if (sel_ram)         read_data = ram_dout;
      else if (sel_sw)     read_data = {8'h00, sw_sync};
      else if (sel_tcount) read_data = count;
      else if (sel_tctrl)  read_data = {13'b0, irq_en, 1'b0, en};
      else if (sel_tcmp)   read_data = compare;
      else if (sel_tstat)  read_data = {15'b0, match};
    end
  end

  // Clear strobe overrides a coincident tick, so it also suppresses match
  always_comb begin
    tick       = en & (prescaler == PRESC_MAX);
    clr_strobe = is_write & sel_tctrl & write_data[1];
    count_inc  = count + 16'd1;
    match_set  = tick & ~clr_strobe & (count_inc == compare);
    match_clr  = is_read & sel_tstat;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_meta <= 8'h00;
      sw_sync <= 8'h00;
    end else begin
      sw_meta <= SW;
      sw_sync <= sw_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      LEDR    <= 8'h00;
      bus_err <= 1'b0;
    end else begin
      if (is_write & sel_led) LEDR <= write_data[7:0];
      if (err_c) bus_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler <= '0;
      count     <= 16'h0000;
      en        <= 1'b0;
      irq_en    <= 1'b0;
      compare   <= 16'hFFFF;
      match     <= 1'b0;
    end else begin
      if (clr_strobe) begin
        prescaler <= '0;
        count     <= 16'h0000;
      end else if (tick) begin
        prescaler <= '0;
        count     <= count_inc;
      end else if (en) begin
        prescaler <= prescaler + PW'(1);
      end
      if (is_write & sel_tctrl) begin
        en     <= write_data[0];
        irq_en <= write_data[2];
      end
      if (is_write & sel_tcmp) compare <= write_data;
      if (match_set)      match <= 1'b1;
      else if (match_clr) match <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_io_bridge.sv
// Scoreboard bench for mem_io_bridge: a PRESCALE=4 instance for the bus/timer
// behaviour and a PRESCALE=1 instance for the 16-bit counter wrap.
module tb_mem_io_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  mem_cmd = 2'b00;
  logic [8:0]  mem_addr = 9'h000;
  logic [15:0] write_data = 16'h0000;
  logic [15:0] read_data;
  logic        ram_write;
  logic [7:0]  ram_addr;
  logic [15:0] ram_din;
  logic [15:0] ram_dout;
  logic [7:0]  SW = 8'h00;
  logic [7:0]  LEDR;
  logic        timer_irq;
  logic        bus_err;

  logic [1:0]  cmd1 = 2'b00;
  logic [8:0]  addr1 = 9'h000;
  logic [15:0] wdata1 = 16'h0000;
  logic [15:0] read_data1;
  logic        ram_write1;
  logic [7:0]  ram_addr1;
  logic [15:0] ram_din1;
  logic [7:0]  LEDR1;
  logic        timer_irq1;
  logic        bus_err1;

  logic [15:0] ram_mem [0:255];

  always #5 clk = ~clk;

  mem_io_bridge #(.PRESCALE(4), .RAM_DEPTH_LOG2(8)) dut (
    .clk(clk), .reset(reset), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
    .write_data(write_data), .read_data(read_data), .ram_write(ram_write),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout), .SW(SW),
    .LEDR(LEDR), .timer_irq(timer_irq), .bus_err(bus_err)
  );

  mem_io_bridge #(.PRESCALE(1), .RAM_DEPTH_LOG2(8)) dut1 (
    .clk(clk), .reset(reset), .mem_cmd(cmd1), .mem_addr(addr1),
    .write_data(wdata1), .read_data(read_data1), .ram_write(ram_write1),
    .ram_addr(ram_addr1), .ram_din(ram_din1), .ram_dout(16'h0000), .SW(8'h00),
    .LEDR(LEDR1), .timer_irq(timer_irq1), .bus_err(bus_err1)
  );

  // External RAM model: synchronous write, asynchronous read
  always @(posedge clk) if (ram_write) ram_mem[ram_addr] <= ram_din;
  assign ram_dout = ram_mem[ram_addr];

  localparam int S_RD = 0, S_LED = 1, S_RW = 2, S_ERR = 3, S_IRQ = 4, S_RA = 5;
  localparam int S_RD1 = 6, S_IRQ1 = 7, S_ERR1 = 8, S_DIN1 = 9, S_LED1 = 10, S_RW1 = 11, S_RA1 = 12;

  typedef struct {
    int          sel;
    logic [15:0] exp;
    string       name;
  } exp_t;

  exp_t        sb [$];
  int          tests = 0;
  int          failed = 0;
  exp_t        mon_e;
  logic [15:0] mon_act;

  function automatic logic [15:0] observe(input int sel);
    case (sel)
      S_RD:    return read_data;
      S_LED:   return {8'h00, LEDR};
      S_RW:    return {15'h0, ram_write};
      S_ERR:   return {15'h0, bus_err};
      S_IRQ:   return {15'h0, timer_irq};
      S_RA:    return {8'h00, ram_addr};
      S_RD1:   return read_data1;
      S_IRQ1:  return {15'h0, timer_irq1};
      S_ERR1:  return {15'h0, bus_err1};
      S_DIN1:  return ram_din1;
      S_LED1:  return {8'h00, LEDR1};
      S_RW1:   return {15'h0, ram_write1};
      default: return {8'h00, ram_addr1};
    endcase
  endfunction

  task automatic expect_val(input int sel, input logic [15:0] v, input string name);
    exp_t e;
    e.sel = sel;
    e.exp = v;
    e.name = name;
    sb.push_back(e);
  endtask

  // Monitor: everything queued in the current cycle is checked at the falling edge
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      mon_e = sb.pop_front();
      mon_act = observe(mon_e.sel);
      tests++;
      if (mon_act !== mon_e.exp) begin
        failed++;
        $display("FAIL %s: got 0x%04h, expected 0x%04h", mon_e.name, mon_act, mon_e.exp);
      end
    end
  end

  task automatic step(input logic [1:0] c, input logic [8:0] a, input logic [15:0] d);
    @(posedge clk);
    #1;
    mem_cmd = c;
    mem_addr = a;
    write_data = d;
  endtask

  task automatic step1(input logic [1:0] c, input logic [8:0] a, input logic [15:0] d);
    @(posedge clk);
    #1;
    cmd1 = c;
    addr1 = a;
    wdata1 = d;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    mem_cmd = 2'b00;
    expect_val(S_ERR, 16'h0, "bus_err_cleared_by_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    mem_cmd = 2'b10;
    mem_addr = 9'h100;
    write_data = 16'h00AB;

    // Reset held with an LED write pending, and a RAM write attempted
    step(2'b10, 9'h010, 16'hBEEF);
    expect_val(S_RW, 16'h0, "ram_write_in_reset");
    expect_val(S_LED, 16'h0, "led_in_reset");
    expect_val(S_IRQ, 16'h0, "irq_in_reset");
    step(2'b10, 9'h100, 16'h00AB);
    reset = 1'b0;
    expect_val(S_LED, 16'h0, "led_before_first_edge");
    step(2'b00, 9'h000, 16'h0000);
    expect_val(S_LED, 16'h00AB, "led_write");
    expect_val(S_ERR, 16'h0, "bus_err_after_led");
    step(2'b01, 9'h182, 16'h0000);
    expect_val(S_RD, 16'hFFFF, "tcmp_reset_value");
    step(2'b01, 9'h181, 16'h0000);
    expect_val(S_RD, 16'h0000, "tctrl_reset_value");

    // RAM write then read back
    step(2'b10, 9'h005, 16'h1234);
    expect_val(S_RW, 16'h1, "ram_write_strobe");
    expect_val(S_RA, 16'h0005, "ram_addr");
    step(2'b01, 9'h005, 16'h0000);
    expect_val(S_RD, 16'h1234, "ram_read");
    expect_val(S_RW, 16'h0, "ram_write_on_read");
    step(2'b00, 9'h005, 16'h0000);
    expect_val(S_RD, 16'h0000, "read_data_idle");
    expect_val(S_ERR, 16'h0, "bus_err_after_ram");

    // Switch synchroniser latency
    step(2'b01, 9'h140, 16'h0000);
    SW = 8'h5A;
    expect_val(S_RD, 16'h0000, "sw_edge0");
    step(2'b01, 9'h140, 16'h0000);
    expect_val(S_RD, 16'h0000, "sw_edge1");
    step(2'b01, 9'h140, 16'h0000);
    expect_val(S_RD, 16'h005A, "sw_edge2");

    // Timer: TCMP=3, enable with irq; count hits 3 twelve edges after enabling
    step(2'b10, 9'h182, 16'h0003);
    step(2'b10, 9'h181, 16'h0005);
    repeat (11) step(2'b00, 9'h000, 16'h0000);
    step(2'b01, 9'h180, 16'h0000);
    expect_val(S_RD, 16'h0002, "count_after_11");
    expect_val(S_IRQ, 16'h0, "irq_before_match");
    step(2'b01, 9'h180, 16'h0000);
    expect_val(S_RD, 16'h0003, "count_after_12");
    expect_val(S_IRQ, 16'h1, "irq_on_match");
    step(2'b01, 9'h183, 16'h0000);
    expect_val(S_RD, 16'h0001, "tstat_set");
    step(2'b01, 9'h183, 16'h0000);
    expect_val(S_RD, 16'h0000, "tstat_cleared");
    expect_val(S_IRQ, 16'h0, "irq_cleared");
    step(2'b10, 9'h181, 16'h0000);
    step(2'b01, 9'h180, 16'h0000);
    expect_val(S_RD, 16'h0004, "count_tick_before_disable");
    step(2'b01, 9'h181, 16'h0000);
    expect_val(S_RD, 16'h0000, "tctrl_readback");
    expect_val(S_ERR, 16'h0, "bus_err_after_timer");

    // Clear strobe colliding with a tick that would otherwise match
    step(2'b10, 9'h181, 16'h0003);
    repeat (10) step(2'b00, 9'h000, 16'h0000);
    step(2'b01, 9'h180, 16'h0000);
    expect_val(S_RD, 16'h0002, "count_before_clear");
    step(2'b10, 9'h181, 16'h0003);
    step(2'b01, 9'h183, 16'h0000);
    expect_val(S_RD, 16'h0000, "no_match_on_clear");
    step(2'b01, 9'h180, 16'h0000);
    expect_val(S_RD, 16'h0000, "count_cleared");
    repeat (2) step(2'b00, 9'h000, 16'h0000);
    step(2'b01, 9'h180, 16'h0000);
    expect_val(S_RD, 16'h0001, "prescaler_cleared");

    // Bus error sources, each from a fresh reset
    do_reset();
    step(2'b01, 9'h1FF, 16'h0000);
    expect_val(S_RD, 16'h0000, "unmapped_read_data");
    expect_val(S_ERR, 16'h0, "bus_err_not_yet");
    step(2'b00, 9'h000, 16'h0000);
    expect_val(S_ERR, 16'h1, "bus_err_unmapped");
    step(2'b00, 9'h000, 16'h0000);
    expect_val(S_ERR, 16'h1, "bus_err_sticky");
    do_reset();
    step(2'b10, 9'h180, 16'h0055);
    step(2'b01, 9'h180, 16'h0000);
    expect_val(S_ERR, 16'h1, "bus_err_ro_write");
    expect_val(S_RD, 16'h0000, "tcount_unchanged");
    do_reset();
    step(2'b10, 9'h183, 16'h0001);
    step(2'b00, 9'h000, 16'h0000);
    expect_val(S_ERR, 16'h1, "bus_err_tstat_write");
    do_reset();
    step(2'b11, 9'h005, 16'h0077);
    expect_val(S_RW, 16'h0, "ram_write_cmd11");
    expect_val(S_RD, 16'h0000, "read_data_cmd11");
    step(2'b00, 9'h000, 16'h0000);
    expect_val(S_ERR, 16'h1, "bus_err_cmd11");
    do_reset();
    step(2'b01, 9'h005, 16'h0000);
    expect_val(S_RD, 16'h1234, "ram_kept_after_cmd11");
    step(2'b00, 9'h000, 16'h0000);
    expect_val(S_ERR, 16'h0, "ram_read_no_err");

    // Counter wrap on the PRESCALE=1 instance: TCMP=0 so the wrap edge matches
    step1(2'b10, 9'h182, 16'h0000);
    expect_val(S_DIN1, 16'h0000, "ram_din_passthrough");
    expect_val(S_RW1, 16'h0, "ram_write_io_addr");
    expect_val(S_RA1, 16'h0082, "ram_addr_low_bits");
    step1(2'b10, 9'h181, 16'h0005);
    step1(2'b00, 9'h000, 16'h0000);
    repeat (65535) @(posedge clk);
    #1;
    cmd1 = 2'b01;
    addr1 = 9'h180;
    expect_val(S_RD1, 16'hFFFF, "count_ffff");
    step1(2'b01, 9'h180, 16'h0000);
    expect_val(S_RD1, 16'h0000, "count_wrap");
    expect_val(S_IRQ1, 16'h1, "irq_on_wrap_match");
    step1(2'b01, 9'h183, 16'h0000);
    expect_val(S_RD1, 16'h0001, "tstat_wrap");
    step1(2'b01, 9'h183, 16'h0000);
    expect_val(S_RD1, 16'h0000, "tstat_wrap_cleared");
    expect_val(S_ERR1, 16'h0, "bus_err_wrap_dut");
    expect_val(S_LED1, 16'h0000, "led_untouched");

    step(2'b00, 9'h000, 16'h0000);
    @(negedge clk);
    #1;
    tests++;
    if (sb.size() != 0) begin
      failed++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
